// File: rtl/muldiv_unit.sv
// ============================================================================
// muldiv_unit
// ----------------------------------------------------------------------------
// Iterative RV32M-style multiply/divide unit. A request is accepted with a
// valid/ready handshake, the operands are latched, and the result is offered
// with a second valid/ready handshake until the consumer takes it.
//
// Multiply is a shift-add over 2*XLEN-bit magnitudes. Divide is restoring
// division producing one quotient bit per cycle. Both take exactly XLEN
// BUSY cycles. Divide-by-zero and signed overflow skip BUSY entirely.
//
// Configuration macro:
//   MULDIV_DIV_EN  - when defined, DIV/DIVU/REM/REMU are implemented.
//                    When undefined, the divide datapath is absent and any
//                    funct3[2]=1 request completes in one cycle with result 0.
//
// Parameters:
//   XLEN       operand/result width (even, 8..64)
//
// Ports:
//   i_clk      clock, all state changes on its rising edge
//   i_rst      synchronous active-high reset
//   i_valid    request valid
//   o_ready    unit is idle and can accept a request
//   i_funct3   000 MUL, 001 MULH, 010 MULHSU, 011 MULHU,
//              100 DIV, 101 DIVU, 110 REM, 111 REMU
//   i_op_a     rs1 (multiplicand / dividend)
//   i_op_b     rs2 (multiplier / divisor)
//   i_flush    abort any in-flight operation
//   o_valid    o_result is valid
//   i_ready    consumer accepts the result
//   o_result   result, zero whenever o_valid is low
// ============================================================================
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [2:0]      i_funct3,
    input  logic [XLEN-1:0] i_op_a,
    input  logic [XLEN-1:0] i_op_b,
    input  logic            i_flush,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [XLEN-1:0] o_result
);

    localparam int CW = $clog2(XLEN) + 1;

    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_stateNext;

    // Datapath registers. r_x/r_y/r_acc are shared between multiply and
    // divide:
    //   multiply: r_x = shifting multiplicand, r_y = shifting multiplier,
    //             r_acc = running product
    //   divide:   r_x[XLEN-1:0] = dividend shifting out / quotient shifting in,
    //             r_y = divisor magnitude, r_acc[XLEN-1:0] = partial remainder
    logic [CW-1:0]     r_count;
    logic [2:0]        r_funct3;
    logic [2*XLEN-1:0] r_x;
    logic [XLEN-1:0]   r_y;
    logic [2*XLEN-1:0] r_acc;
    logic              r_negRes;
    logic [XLEN-1:0]   r_result;

    logic              w_accept;
    logic              w_lastStep;
    logic              w_aSigned;
    logic              w_bSigned;
    logic              w_aNeg;
    logic              w_bNeg;
    logic [XLEN-1:0]   w_aMag;
    logic [XLEN-1:0]   w_bMag;
    logic              w_negRes;
    logic              w_bypass;
    logic [XLEN-1:0]   w_bypassResult;

    logic [2*XLEN-1:0] w_prodNext;
    logic [2*XLEN-1:0] w_prodFinal;
    logic [XLEN-1:0]   w_mulResult;
    logic [XLEN-1:0]   w_stepResult;

`ifdef MULDIV_DIV_EN
    logic              r_negRem;
    logic              w_negRem;
    logic [XLEN:0]     w_remShift;
    logic [XLEN:0]     w_trial;
    logic              w_qBit;
    logic [XLEN-1:0]   w_remNext;
    logic [XLEN-1:0]   w_quotNext;
    logic [XLEN-1:0]   w_quotFinal;
    logic [XLEN-1:0]   w_remFinal;
    logic [XLEN-1:0]   w_divResult;
`endif

    assign w_lastStep = (r_count == CW'(1));
    assign o_result   = r_result;

    // Operand preparation: decide which operands are interpreted as signed,
    // then reduce both to magnitudes. The core loops only ever see unsigned
    // values and the sign is reapplied to the final result. MUL keeps both
    // operands unsigned since the low half of the product is sign-agnostic.
    always_comb begin
        w_aSigned = (i_funct3 == 3'b001) || (i_funct3 == 3'b010);
        w_bSigned = (i_funct3 == 3'b001);
`ifdef MULDIV_DIV_EN
        if (i_funct3[2]) begin
            w_aSigned = !i_funct3[0];
            w_bSigned = !i_funct3[0];
        end
`endif
        w_aNeg   = w_aSigned && i_op_a[XLEN-1];
        w_bNeg   = w_bSigned && i_op_b[XLEN-1];
        w_aMag   = w_aNeg ? (-i_op_a) : i_op_a;
        w_bMag   = w_bNeg ? (-i_op_b) : i_op_b;
        w_negRes = w_aNeg ^ w_bNeg;
`ifdef MULDIV_DIV_EN
        w_negRem = w_aNeg;
`endif
    end

    // Requests that complete without any iteration. Their result is known at
    // the accept edge so the FSM jumps straight from IDLE to DONE.
    always_comb begin
        w_bypass       = 1'b0;
        w_bypassResult = '0;
`ifdef MULDIV_DIV_EN
        if (i_funct3[2]) begin
            if (i_op_b == '0) begin
                w_bypass       = 1'b1;
                w_bypassResult = i_funct3[1] ? i_op_a : ALL_ONES;
            end else if (!i_funct3[0] && (i_op_a == MOST_NEG) && (i_op_b == ALL_ONES)) begin
                w_bypass       = 1'b1;
                w_bypassResult = i_funct3[1] ? '0 : MOST_NEG;
            end
        end
`else
        if (i_funct3[2]) begin
            w_bypass       = 1'b1;
            w_bypassResult = '0;
        end
`endif
    end

    // One shift-add multiply step plus the signed fix-up of the product that
    // this step would produce. The fix-up is only captured on the last step.
    always_comb begin
        w_prodNext  = r_acc + (r_y[0] ? r_x : '0);
        w_prodFinal = r_negRes ? (-w_prodNext) : w_prodNext;
        w_mulResult = (r_funct3 == 3'b000) ? w_prodFinal[XLEN-1:0]
                                           : w_prodFinal[2*XLEN-1:XLEN];
    end

`ifdef MULDIV_DIV_EN
    // One restoring-division step: shift the next dividend bit into the
    // partial remainder and subtract the divisor. A borrow (MSB of the
    // XLEN+1-bit trial set) means the subtraction is undone and the quotient
    // bit is 0. The remainder follows the dividend's sign, the quotient
    // follows sign(a) xor sign(b).
    always_comb begin
        w_remShift  = {r_acc[XLEN-1:0], r_x[XLEN-1]};
        w_trial     = w_remShift - {1'b0, r_y};
        w_qBit      = !w_trial[XLEN];
        w_remNext   = w_qBit ? w_trial[XLEN-1:0] : w_remShift[XLEN-1:0];
        w_quotNext  = {r_x[XLEN-2:0], w_qBit};
        w_quotFinal = r_negRes ? (-w_quotNext) : w_quotNext;
        w_remFinal  = r_negRem ? (-w_remNext) : w_remNext;
        w_divResult = r_funct3[1] ? w_remFinal : w_quotFinal;
    end
`endif

    // Select the finished value for whichever operation is iterating.
    always_comb begin
`ifdef MULDIV_DIV_EN
        w_stepResult = r_funct3[2] ? w_divResult : w_mulResult;
`else
        w_stepResult = w_mulResult;
`endif
    end

    // Next-state logic and handshake outputs. Flush overrides everything,
    // including an accept or result handshake in the same cycle. A result
    // handshake returns to IDLE, so o_ready can only rise one cycle later.
    always_comb begin
        w_stateNext = r_state;
        w_accept    = 1'b0;
        o_ready     = (r_state == IDLE);
        o_valid     = (r_state == DONE);
        case (r_state)
            IDLE: begin
                if (i_valid) begin
                    w_accept    = 1'b1;
                    w_stateNext = w_bypass ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (w_lastStep) begin
                    w_stateNext = DONE;
                end
            end
            DONE: begin
                if (i_ready) begin
                    w_stateNext = IDLE;
                end
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
        if (i_flush) begin
            w_stateNext = IDLE;
            w_accept    = 1'b0;
        end
    end

    // State register; reset has priority over flush and handshakes.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Operand latch and iteration. Operands are captured only at the accept
    // edge, so input changes afterwards are invisible. The counter is loaded
    // with XLEN and the FSM leaves BUSY when the step at count 1 completes.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count  <= '0;
            r_funct3 <= '0;
            r_x      <= '0;
            r_y      <= '0;
            r_acc    <= '0;
            r_negRes <= 1'b0;
`ifdef MULDIV_DIV_EN
            r_negRem <= 1'b0;
`endif
        end else if (i_flush) begin
            r_count <= '0;
        end else if (w_accept) begin
            r_funct3 <= i_funct3;
            r_x      <= {{XLEN{1'b0}}, w_aMag};
            r_y      <= w_bMag;
            r_acc    <= '0;
            r_negRes <= w_negRes;
`ifdef MULDIV_DIV_EN
            r_negRem <= w_negRem;
`endif
            r_count  <= w_bypass ? '0 : CW'(XLEN);
        end else if (r_state == BUSY) begin
`ifdef MULDIV_DIV_EN
            if (r_funct3[2]) begin
                r_x[XLEN-1:0]   <= w_quotNext;
                r_acc[XLEN-1:0] <= w_remNext;
            end else begin
                r_acc <= w_prodNext;
                r_x   <= r_x << 1;
                r_y   <= r_y >> 1;
            end
`else
            r_acc <= w_prodNext;
            r_x   <= r_x << 1;
            r_y   <= r_y >> 1;
`endif
            r_count <= r_count - CW'(1);
        end
    end

    // Result register. It is written only on entry to DONE and cleared on
    // every way out of DONE, which keeps o_result at zero whenever o_valid
    // is low and holds it stable while the consumer stalls.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_result <= '0;
        end else if (w_accept && w_bypass) begin
            r_result <= w_bypassResult;
        end else if ((r_state == BUSY) && w_lastStep) begin
            r_result <= w_stepResult;
        end else if ((r_state == DONE) && i_ready) begin
            r_result <= '0;
        end
    end

endmodule
